// File: rtl/arith_pkg.sv
// arith_pkg: shared state encodings and default widths for the arithmetic datapath
package arith_pkg;
   localparam int DEF_DIVIDEND_W = 32;
   localparam int DEF_DIVISOR_W  = 16;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_DONE = 2'd2} state_t;
   function automatic int cnt_w(input int w);
      return $clog2(w);
   endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration, conditional subtract of the divisor
module div_step #(
   parameter int DIVISOR_W = 16
) (
   input  logic [DIVISOR_W:0]   i_rem,
   input  logic [DIVISOR_W-1:0] i_divisor,
   output logic [DIVISOR_W-1:0] o_rem,
   output logic                 o_q_bit
);
   logic [DIVISOR_W-1:0] w_diff;
   // the result is always below the divisor, so the low bits of the difference suffice
   assign w_diff  = i_rem[DIVISOR_W-1:0] - i_divisor;
   assign o_q_bit = i_rem >= {1'b0, i_divisor};
   assign o_rem   = o_q_bit ? w_diff : i_rem[DIVISOR_W-1:0];
endmodule

// File: rtl/divider_32by16_seq.sv
// divider_32by16_seq: restoring radix-2 unsigned divider, one quotient bit per clock,
// valid/ready handshakes on operands and result
module divider_32by16_seq
   import arith_pkg::*;
#(
   parameter int DIVIDEND_W = DEF_DIVIDEND_W,
   parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);
   localparam int CNT_W = cnt_w(DIVIDEND_W);
   state_t                r_state, w_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [DIVIDEND_W-1:0] r_shift, r_quo;
   logic [DIVISOR_W-1:0]  r_rem, r_div, r_rem_out, w_rem_out;
   logic [DIVISOR_W:0]    w_rem_in;
   logic                  r_dbz, w_q_bit, w_accept, w_last;

   assign in_ready    = rst_n && r_state == ST_IDLE;
   assign out_valid   = r_state == ST_DONE;
   assign w_accept    = in_valid && in_ready;
   assign w_last      = r_cnt == CNT_W'(DIVIDEND_W - 1);
   assign w_rem_in    = {r_rem, r_shift[DIVIDEND_W-1]};
   assign quotient    = r_quo;
   assign remainder   = r_rem_out;
   assign div_by_zero = r_dbz;

   div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
      .i_rem     (w_rem_in),
      .i_divisor (r_div),
      .o_rem     (w_rem_out),
      .o_q_bit   (w_q_bit)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = divisor == '0 ? ST_DONE : ST_CALC;
         ST_CALC: if (w_last) w_next = ST_DONE;
         ST_DONE: if (out_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_shift   <= '0;
         r_rem     <= '0;
         r_div     <= '0;
         r_quo     <= '0;
         r_rem_out <= '0;
         r_dbz     <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_shift <= dividend;
            r_div   <= divisor;
            r_rem   <= '0;
            r_cnt   <= '0;
            if (divisor == '0) begin
               r_quo     <= '1;
               r_rem_out <= dividend[DIVISOR_W-1:0];
               r_dbz     <= 1'b1;
            end
         end else if (r_state == ST_CALC) begin
            // the dividend register empties from the top while quotient bits fill from the bottom
            r_shift <= {r_shift[DIVIDEND_W-2:0], w_q_bit};
            r_rem   <= w_rem_out;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
               r_quo     <= {r_shift[DIVIDEND_W-2:0], w_q_bit};
               r_rem_out <= w_rem_out;
               r_dbz     <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_divider_32by16_seq.sv
// tb_divider_32by16_seq: directed and random operand pairs, scoreboard of reference
// quotient/remainder/latency checked whenever the divider presents a result
module tb_divider_32by16_seq;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        in_ready, out_valid, div_by_zero;
   logic [31:0] quotient;
   logic [15:0] remainder;
   int          n_chk = 0, n_fail = 0, cyc = 0, ready_mode = 1;

   typedef struct {
      logic [31:0] a, q;
      logic [15:0] b, r;
      logic        dbz;
      int          lat, acc;
   } exp_t;
   exp_t sb[$];

   divider_32by16_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1 out_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode == 1;
   end

   // monitor and scoreboard: operands are modelled on accept, results compared while presented
   initial begin
      logic prev_ov;
      exp_t e;
      prev_ov = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete();
            prev_ov = 1'b0;
         end else begin
            if (out_valid) begin
               if (sb.size() == 0) chk("unexpected out_valid", 1, 0);
               else begin
                  if (!prev_ov) chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                  chk("quotient", 64'(quotient), 64'(sb[0].q));
                  chk("remainder", 64'(remainder), 64'(sb[0].r));
                  chk("div_by_zero", 64'(div_by_zero), 64'(sb[0].dbz));
                  if (out_ready) begin
                     e = sb.pop_front();
                     if (!e.dbz) chk("q*b+r", 64'(quotient) * 64'(e.b) + 64'(remainder), 64'(e.a));
                  end
               end
            end
            if (in_valid && in_ready) begin
               e.a   = dividend;
               e.b   = divisor;
               e.dbz = divisor == 0;
               e.q   = e.dbz ? 32'hFFFF_FFFF : dividend / 32'(divisor);
               e.r   = e.dbz ? dividend[15:0] : 16'(dividend % 32'(divisor));
               e.lat = e.dbz ? 1 : 33;
               e.acc = cyc;
               sb.push_back(e);
            end
            prev_ov = out_valid && !out_ready;
         end
      end
   end

   task automatic do_op(input logic [31:0] a, input logic [15:0] b);
      int t = 0;
      @(posedge clk);
      #1 in_valid = 1'b1; dividend = a; divisor = b;
      @(negedge clk);
      while (!in_ready && t < 300) begin
         t++;
         @(negedge clk);
      end
      if (t >= 300) chk("accept timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 1'b0; dividend = $urandom; divisor = 16'($urandom);
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((sb.size() != 0 || !in_ready) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) chk("idle timeout", 0, 1);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, " in_ready"}, 64'(in_ready), 0);
      chk({name, " out_valid"}, 64'(out_valid), 0);
      chk({name, " quotient"}, 64'(quotient), 0);
      chk({name, " remainder"}, 64'(remainder), 0);
      chk({name, " div_by_zero"}, 64'(div_by_zero), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      #2 chk_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready after reset", 64'(in_ready), 1);
      do_op(32'hFFFE0001, 16'hFFFF);
      wait_idle();
      do_op(32'h06260060, 16'h5678);
      do_op(32'd131071, 16'd2);
      do_op(32'h12345678, 16'd0);
      wait_idle();
      ready_mode = 0;
      do_op(32'd1000, 16'd3);
      t = 0;
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("backpressure out_valid", 64'(out_valid), 1);
      #1 in_valid = 1'b1; dividend = 32'd55; divisor = 16'd5;
      repeat (10) begin
         @(negedge clk);
         chk("in_ready under backpressure", 64'(in_ready), 0);
         chk("out_valid under backpressure", 64'(out_valid), 1);
      end
      @(posedge clk);
      #1 in_valid = 1'b0; ready_mode = 1;
      t = 0;
      @(negedge clk);
      while (!(out_valid && out_ready) && t < 10) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      chk("in_ready after release", 64'(in_ready), 1);
      chk("out_valid after release", 64'(out_valid), 0);
      chk("quotient held after release", 64'(quotient), 333);
      do_op(32'd100000, 16'd3);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_reset_outputs("mid-calc reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         chk("aborted op out_valid", 64'(out_valid), 0);
      end
      do_op(32'd100, 16'd7);
      wait_idle();
      ready_mode = 2;
      for (int i = 0; i < 200; i++)
         do_op(i % 4 == 0 ? 32'($urandom_range(0, 70000)) : $urandom, 16'($urandom_range(1, 65535)));
      wait_idle();
      ready_mode = 1;
      chk("scoreboard drained", 64'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
